edge_repeat_pulser: RTL

EDGE_REPEAT_PULSER -- requirements
Module: edge_repeat_pulser

---
 rtl/edge_repeat_pulser_pkg.sv | 29 ++
 rtl/edge_repeat_pulser_channel.sv | 129 ++++++++++++
 rtl/edge_repeat_pulser.sv | 50 +++++
 3 files changed

// File: rtl/edge_repeat_pulser_pkg.sv
// ---------------------------------------------------------------------------
// edge_repeat_pulser_pkg
//   Shared definitions for the edge/repeat pulser slice:
//     state_e    - per-channel FSM encoding (IDLE, DELAY, REPEAT)
//     log2_ceil  - ceiling log2, used to size the hold/repeat counters so
//                  they can count from 0 up to (delay - 1)
// ---------------------------------------------------------------------------
package edge_repeat_pulser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  // Minimum result of 1 keeps counter vectors legal for tiny parameters.
  function automatic int log2_ceil(input int value);
    int result;
    longint span;
    result = 0;
    span   = 1;
    while (span < longint'(value)) begin
      span   = span << 1;
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/edge_repeat_pulser_channel.sv
// ---------------------------------------------------------------------------
// edge_repeat_channel
//   One button channel: edge detection plus hold-to-repeat generation.
//   Ports:
//     clk, rst       - clock, synchronous active-high reset
//     level_in       - debounced level, already synchronous to clk
//     repeat_enable  - masks repeat pulses at press_pulse only
//     rise_pulse     - one cycle after a 0->1 transition
//     fall_pulse     - one cycle after a 1->0 transition
//     press_pulse    - rise pulse OR (enabled) repeat pulse
//     held           - level_in delayed one cycle
// ---------------------------------------------------------------------------
module edge_repeat_channel
  import edge_repeat_pulser_pkg::*;
#(
  parameter int hold_delay           = 25000000,
  parameter int repeat_period        = 5000000,
  parameter int hold_counter_width   = log2_ceil(hold_delay),
  parameter int repeat_counter_width = log2_ceil(repeat_period)
) (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  input  logic repeat_enable,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic press_pulse,
  output logic held
);

  // Terminal counts: the rise-pulse cycle sees count 0, so the repeat pulse
  // lands hold_delay cycles later when the count reads hold_delay-1.
  localparam logic [hold_counter_width-1:0]   HOLD_LAST = hold_counter_width'(hold_delay - 1);
  localparam logic [hold_counter_width-1:0]   HOLD_MAX  = '1;
  localparam logic [repeat_counter_width-1:0] REP_LAST  = repeat_counter_width'(repeat_period - 1);
  localparam logic [repeat_counter_width-1:0] REP_MAX   = '1;

  state_e                          state_q, state_d;
  logic                            prev_q, prev_d;
  logic                            rise_q, rise_d;
  logic                            fall_q, fall_d;
  logic                            press_q, press_d;
  logic [hold_counter_width-1:0]   hold_cnt_q, hold_cnt_d;
  logic [repeat_counter_width-1:0] rep_cnt_q, rep_cnt_d;
  logic                            repeat_fire;

  // Next-state logic. A low level (which always coincides with a detected
  // fall while the FSM is active) returns to IDLE before any terminal-count
  // check, so release always wins over a repeat in the same cycle. The
  // enable only gates press_pulse; the FSM keeps its cadence while masked.
  always_comb begin
    prev_d      = level_in;
    rise_d      = level_in & ~prev_q;
    fall_d      = ~level_in & prev_q;
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    repeat_fire = 1'b0;

    if (!level_in) begin
      state_d    = ST_IDLE;
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_d) begin
            state_d    = ST_DELAY;
            hold_cnt_d = '0;
          end
        end
        ST_DELAY: begin
          if (hold_cnt_q == HOLD_LAST) begin
            repeat_fire = 1'b1;
            state_d     = ST_REPEAT;
            hold_cnt_d  = '0;
            rep_cnt_d   = '0;
          end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + hold_counter_width'(1);
          end
        end
        ST_REPEAT: begin
          if (rep_cnt_q == REP_LAST) begin
            repeat_fire = 1'b1;
            rep_cnt_d   = '0;
          end else if (rep_cnt_q != REP_MAX) begin
            rep_cnt_d = rep_cnt_q + repeat_counter_width'(1);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end
      endcase
    end

    press_d = rise_d | (repeat_fire & repeat_enable);
  end

  // State and output registers. Reset clears prev as well, so a level that
  // is already high when reset releases is reported as a fresh rise, and a
  // channel aborted by reset produces no fall pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      press_q    <= 1'b0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      press_q    <= press_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign press_pulse = press_q;
  assign held        = prev_q;

endmodule

// File: rtl/edge_repeat_pulser.sv
// ---------------------------------------------------------------------------
// edge_repeat_pulser
//   Array of independent button channels sitting right after the debouncer.
//   Ports:
//     clk, rst       - clock, synchronous active-high reset
//     level_in       - [width] debounced levels
//     repeat_enable  - global mask for repeat pulses
//     rise_pulse     - [width] one-cycle pulse on 0->1
//     fall_pulse     - [width] one-cycle pulse on 1->0
//     press_pulse    - [width] rise pulse OR repeat pulse
//     held           - [width] level_in delayed one cycle
// ---------------------------------------------------------------------------
module edge_repeat_pulser
  import edge_repeat_pulser_pkg::*;
#(
  parameter int width                = 1,
  parameter int hold_delay           = 25000000,
  parameter int repeat_period        = 5000000,
  parameter int hold_counter_width   = log2_ceil(hold_delay),
  parameter int repeat_counter_width = log2_ceil(repeat_period)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] level_in,
  input  logic             repeat_enable,
  output logic [width-1:0] rise_pulse,
  output logic [width-1:0] fall_pulse,
  output logic [width-1:0] press_pulse,
  output logic [width-1:0] held
);

  for (genvar i = 0; i < width; i++) begin : g_channel
    edge_repeat_channel #(
      .hold_delay           (hold_delay),
      .repeat_period        (repeat_period),
      .hold_counter_width   (hold_counter_width),
      .repeat_counter_width (repeat_counter_width)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .level_in      (level_in[i]),
      .repeat_enable (repeat_enable),
      .rise_pulse    (rise_pulse[i]),
      .fall_pulse    (fall_pulse[i]),
      .press_pulse   (press_pulse[i]),
      .held          (held[i])
    );
  end

endmodule
